// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus memory-mapped UART TX/RX, cycle counter and stop flag at 0x30000.
// Optional MEM_IO_BOUNDS_CHECK_EN: non-io accesses beyond the RAM are faulted and flagged on access_fault.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_FIFO_LOG2   = 4,
  parameter int FULL_MARGIN    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] bus_a,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_wr,
  output logic [7:0]  bus_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
`ifdef MEM_IO_BOUNDS_CHECK_EN
  output logic        access_fault,
`endif
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int RAM_SIZE = 1 << RAM_ADDR_WIDTH;
  localparam int DEPTH    = 1 << TX_FIFO_LOG2;
  localparam int PW       = TX_FIFO_LOG2 + 1;

  logic [7:0]                r_ram  [RAM_SIZE];
  logic [7:0]                r_fifo [DEPTH];
  logic [PW-1:0]             r_wptr, r_rptr;
  logic [31:0]               r_cyc;
  logic [23:0]               r_snap;
  logic [7:0]                r_rdata;
  logic                      r_stop, r_ovf;

  logic                      w_io, w_ram_ok, w_fault;
  logic [15:0]               w_off;
  logic [RAM_ADDR_WIDTH-1:0] w_idx;
  logic [7:0]                w_rdata, w_push_data;
  logic                      w_push_req, w_push, w_pop, w_full;
  logic [PW-1:0]             w_count, w_free;
  logic                      w_unused_addr_hi;

  assign w_unused_addr_hi = ^bus_a[31:18];
  assign w_io  = (bus_a[17:16] == 2'b11);
  assign w_off = bus_a[15:0];
  assign w_idx = bus_a[RAM_ADDR_WIDTH-1:0];

`ifdef MEM_IO_BOUNDS_CHECK_EN
  assign w_fault = !w_io && ({1'b0, bus_a[17:0]} >= (19'd1 << RAM_ADDR_WIDTH));
`else
  assign w_fault = 1'b0;
`endif
  assign w_ram_ok = !w_io && !w_fault;

  always_comb begin
    w_rdata = '0;
    if (w_ram_ok) begin
      w_rdata = r_ram[w_idx];
    end else if (w_io) begin
      case (w_off)
        16'h0000: w_rdata = rx_valid ? rx_data : '0;
        16'h0004: w_rdata = r_cyc[7:0];
        16'h0005: w_rdata = r_snap[7:0];
        16'h0006: w_rdata = r_snap[15:8];
        16'h0007: w_rdata = r_snap[23:16];
        default:  w_rdata = '0;
      endcase
    end
  end

  // Stop writes push a 0x00 marker; zero writes to the TX port are not data.
  assign w_push_req  = bus_wr && w_io &&
                       (((w_off == 16'h0000) && (bus_wdata != 8'h00)) || (w_off == 16'h0004));
  assign w_push_data = (w_off == 16'h0004) ? 8'h00 : bus_wdata;
  assign w_count     = r_wptr - r_rptr;
  assign w_full      = (w_count == PW'(DEPTH));
  assign w_free      = PW'(DEPTH) - w_count;
  assign tx_valid    = (r_wptr != r_rptr);
  assign tx_data     = r_fifo[r_rptr[TX_FIFO_LOG2-1:0]];
  assign w_pop       = tx_valid && tx_ready;
  assign w_push      = w_push_req && (!w_full || w_pop);

  assign io_buffer_full = (int'(w_free) <= FULL_MARGIN);
  assign rx_pop         = rst_in && !bus_wr && w_io && (w_off == 16'h0000) && rx_valid;
  assign bus_rdata      = r_rdata;
  assign program_stop   = r_stop;
  assign tx_overflow    = r_ovf;

  always_ff @(posedge clk_in) begin
    if (bus_wr && w_ram_ok) r_ram[w_idx] <= bus_wdata;
    if (w_push) r_fifo[r_wptr[TX_FIFO_LOG2-1:0]] <= w_push_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rdata <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cyc   <= '0;
      r_snap  <= '0;
      r_stop  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
      if (!bus_wr) begin
        r_rdata <= w_rdata;
        if (w_io && (w_off == 16'h0004)) r_snap <= r_cyc[31:8];
      end
      if (bus_wr && w_io && (w_off == 16'h0004)) r_stop <= 1'b1;
      if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

`ifdef MEM_IO_BOUNDS_CHECK_EN
  logic r_fault;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)      r_fault <= 1'b0;
    else if (w_fault) r_fault <= 1'b1;
  end
  assign access_fault = r_fault;
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: randomized bus traffic against a queue/array reference model.
module tb_mem_io_responder;
  localparam int RAM_ADDR_WIDTH = 17;
  localparam int RAM_SIZE       = 1 << RAM_ADDR_WIDTH;
  localparam int DEPTH          = 16;
  localparam int FULL_MARGIN    = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] bus_a = '0;
  logic [7:0]  bus_wdata = '0;
  logic        bus_wr = 1'b0;
  logic [7:0]  bus_rdata, tx_data, rx_data = '0;
  logic        io_buffer_full, tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, rx_pop;
  logic        program_stop, tx_overflow;
`ifdef MEM_IO_BOUNDS_CHECK_EN
  logic        access_fault;
`endif

  mem_io_responder #(
    .RAM_ADDR_WIDTH(RAM_ADDR_WIDTH),
    .TX_FIFO_LOG2(4),
    .FULL_MARGIN(FULL_MARGIN)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .bus_a(bus_a), .bus_wdata(bus_wdata), .bus_wr(bus_wr),
    .bus_rdata(bus_rdata), .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
`ifdef MEM_IO_BOUNDS_CHECK_EN
    .access_fault(access_fault),
`endif
    .program_stop(program_stop), .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  m_ram [int];
  logic [7:0]  m_q [$];
  logic [7:0]  m_rdata;
  logic        m_stop, m_ovf, m_fault;
  logic [31:0] m_snap;
  logic [31:0] tb_cyc;
  int unsigned ram_addrs [$];

  always @(posedge clk_in or negedge rst_in)
    if (!rst_in) tb_cyc <= '0;
    else         tb_cyc <= tb_cyc + 32'd1;

  function automatic void model_reset();
    m_rdata = '0; m_stop = 0; m_ovf = 0; m_fault = 0; m_snap = '0;
    m_q.delete();
  endfunction

  function automatic void model_step();
    int unsigned a18 = bus_a[17:0];
    int unsigned off = bus_a[15:0];
    int          idx = int'(a18 % RAM_SIZE);
    bit          io  = (bus_a[17:16] == 2'b11);
    bit          fault = 0;
    bit          push_req = 0;
    logic [7:0]  pv = '0;
`ifdef MEM_IO_BOUNDS_CHECK_EN
    fault = !io && (a18 >= RAM_SIZE);
    if (fault) m_fault = 1;
`endif
    if (bus_wr) begin
      if (!io && !fault) m_ram[idx] = bus_wdata;
      else if (io && off == 0 && bus_wdata != 0) begin push_req = 1; pv = bus_wdata; end
      else if (io && off == 4) begin push_req = 1; pv = 8'h00; m_stop = 1; end
    end else begin
      if (fault) m_rdata = 8'h00;
      else if (!io) m_rdata = m_ram.exists(idx) ? m_ram[idx] : 8'h00;
      else case (off)
        0: m_rdata = rx_valid ? rx_data : 8'h00;
        4: begin m_rdata = tb_cyc[7:0]; m_snap = tb_cyc; end
        5: m_rdata = m_snap[15:8];
        6: m_rdata = m_snap[23:16];
        7: m_rdata = m_snap[31:24];
        default: m_rdata = 8'h00;
      endcase
    end
    if (m_q.size() > 0 && tx_ready) void'(m_q.pop_front());
    if (push_req) begin
      if (m_q.size() < DEPTH) m_q.push_back(pv);
      else m_ovf = 1;
    end
  endfunction

  task automatic bus(input logic [31:0] a, input logic [7:0] d, input logic wr);
    bus_a = a; bus_wdata = d; bus_wr = wr;
    model_step();
    @(posedge clk_in); #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in); rst_in = 1'b1;
  endtask

  task automatic test_reset();
    bus_a = 32'h30000; bus_wr = 0; rx_valid = 1; rx_data = 8'h55; tx_ready = 1;
    rst_in = 1'b0; model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    n_checks++; if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", bus_rdata); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", io_buffer_full); end
    n_checks++; if (rx_pop !== 1'b0) begin n_fail++; $display("FAIL reset_rx_pop: got %b want 0", rx_pop); end
    n_checks++; if (program_stop !== 1'b0 || tx_overflow !== 1'b0) begin n_fail++;
      $display("FAIL reset_flags: got stop=%b ovf=%b want 0 0", program_stop, tx_overflow); end
`ifdef MEM_IO_BOUNDS_CHECK_EN
    n_checks++; if (access_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", access_fault); end
`endif
    rx_valid = 0; tx_ready = 0;
    @(negedge clk_in); rst_in = 1'b1;
    bus(32'h30005, 8'h00, 1'b0);
    n_checks++; if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_snapshot: got %h want 00", bus_rdata); end
  endtask

  task automatic test_ram();
    logic [7:0] early;
    bus(32'h00011, 8'h5A, 1'b1);
    bus(32'h00010, 8'hA5, 1'b1);
    bus(32'h00011, 8'h00, 1'b0);
    early = bus_rdata;
    bus(32'h00010, 8'h00, 1'b0);
    n_checks++; if (bus_rdata !== 8'hA5) begin n_fail++; $display("FAIL ram_latency: got %h want a5", bus_rdata); end
    n_checks++; if (early === 8'hA5) begin n_fail++; $display("FAIL ram_early: got %h want not a5", early); end
    for (int i = 0; i < 24; i++) begin
      int unsigned a = $urandom_range(0, RAM_SIZE - 1);
      ram_addrs.push_back(a);
      bus(a, 8'($urandom), 1'b1);
      if (i % 3 == 2) begin
        int unsigned r = ram_addrs[$urandom_range(0, ram_addrs.size() - 1)];
        bus(r, 8'h00, 1'b0);
        n_checks++; if (bus_rdata !== m_rdata) begin n_fail++;
          $display("FAIL ram_random @%h: got %h want %h", r, bus_rdata, m_rdata); end
      end
    end
    bus(32'h20010, 8'h3C, 1'b1);
    bus(32'h00010, 8'h00, 1'b0);
    n_checks++; if (bus_rdata !== m_rdata) begin n_fail++; $display("FAIL ram_alias: got %h want %h", bus_rdata, m_rdata); end
    bus(32'h20010, 8'h00, 1'b0);
    n_checks++; if (bus_rdata !== m_rdata) begin n_fail++; $display("FAIL ram_high_read: got %h want %h", bus_rdata, m_rdata); end
`ifdef MEM_IO_BOUNDS_CHECK_EN
    n_checks++; if (access_fault !== m_fault) begin n_fail++; $display("FAIL access_fault: got %b want %b", access_fault, m_fault); end
`endif
  endtask

  task automatic test_rx();
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1; rx_data = (i == 0) ? 8'h41 : 8'($urandom_range(1, 255));
      bus_a = 32'h30000; bus_wr = 0; #1;
      n_checks++; if (rx_pop !== 1'b1) begin n_fail++; $display("FAIL rx_pop_pulse: got %b want 1", rx_pop); end
      bus(32'h30000, 8'h00, 1'b0);
      n_checks++; if (bus_rdata !== m_rdata) begin n_fail++; $display("FAIL rx_data: got %h want %h", bus_rdata, m_rdata); end
      bus_a = 32'h00010; #1;
      n_checks++; if (rx_pop !== 1'b0) begin n_fail++; $display("FAIL rx_pop_end: got %b want 0", rx_pop); end
    end
    rx_valid = 0; rx_data = 8'h77;
    bus_a = 32'h30000; bus_wr = 0; #1;
    n_checks++; if (rx_pop !== 1'b0) begin n_fail++; $display("FAIL rx_no_pop: got %b want 0", rx_pop); end
    bus(32'h30000, 8'h00, 1'b0);
    n_checks++; if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL rx_empty: got %h want 00", bus_rdata); end
  endtask

  task automatic test_cycle_counter();
    logic [31:0] expv, got;
    do_reset();
    repeat (300 + $urandom_range(0, 40)) bus(32'h30008, 8'h00, 1'b0);
    expv = tb_cyc;
    got = '0;
    for (int k = 4; k < 8; k++) begin
      bus(32'h30000 + k, 8'h00, 1'b0);
      n_checks++; if (bus_rdata !== m_rdata) begin n_fail++;
        $display("FAIL cyc_byte%0d: got %h want %h", k, bus_rdata, m_rdata); end
      got[(k-4)*8 +: 8] = bus_rdata;
      repeat (k) bus(32'h30008, 8'h00, 1'b0);
    end
    n_checks++; if (got !== expv) begin n_fail++; $display("FAIL cyc_coherent: got %h want %h", got, expv); end
  endtask

  task automatic test_fifo();
    logic [7:0] d;
    do_reset();
    tx_ready = 0;
    for (int i = 0; i < 16; i++) begin
      bus(32'h30000, 8'h61 + 8'(i), 1'b1);
      n_checks++; if (io_buffer_full !== ((DEPTH - m_q.size()) <= FULL_MARGIN)) begin n_fail++;
        $display("FAIL fifo_full_at%0d: got %b want %b", m_q.size(), io_buffer_full, (DEPTH - m_q.size()) <= FULL_MARGIN); end
    end
    bus(32'h30000, 8'h00, 1'b1);
    n_checks++; if (tx_overflow !== 1'b0 || tx_data !== 8'h61) begin n_fail++;
      $display("FAIL fifo_zero_write: got ovf=%b head=%h want 0 61", tx_overflow, tx_data); end
    tx_ready = 1;
    bus(32'h30000, 8'h58, 1'b1);
    tx_ready = 0;
    n_checks++; if (tx_overflow !== 1'b0 || io_buffer_full !== 1'b1 || tx_data !== m_q[0]) begin n_fail++;
      $display("FAIL fifo_push_pop_full: got ovf=%b full=%b head=%h want 0 1 %h", tx_overflow, io_buffer_full, tx_data, m_q[0]); end
    bus(32'h30000, 8'h71, 1'b1);
    n_checks++; if (tx_overflow !== 1'b1) begin n_fail++; $display("FAIL fifo_overflow: got %b want 1", tx_overflow); end
    tx_ready = 1;
    for (int k = 0; k < 40 && m_q.size() > 0; k++) begin
      d = m_q[0];
      n_checks++; if (tx_valid !== 1'b1 || tx_data !== d) begin n_fail++;
        $display("FAIL fifo_order: got v=%b d=%h want 1 %h", tx_valid, tx_data, d); end
      bus(32'h30008, 8'h00, 1'b0);
    end
    repeat (2) bus(32'h30008, 8'h00, 1'b0);
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_empty_ready: got %b want 0", tx_valid); end
    for (int i = 0; i < 120; i++) begin
      tx_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) != 0)
        bus(32'h30000, ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255)), 1'b1);
      else
        bus(32'h30008, 8'h00, 1'b0);
      n_checks++;
      if (tx_valid !== (m_q.size() > 0) || io_buffer_full !== ((DEPTH - m_q.size()) <= FULL_MARGIN) ||
          tx_overflow !== m_ovf || (m_q.size() > 0 && tx_data !== m_q[0])) begin
        n_fail++;
        $display("FAIL fifo_random%0d: got v=%b f=%b o=%b d=%h want v=%b f=%b o=%b n=%0d", i, tx_valid,
                 io_buffer_full, tx_overflow, tx_data, m_q.size() > 0, (DEPTH - m_q.size()) <= FULL_MARGIN, m_ovf, m_q.size());
      end
    end
  endtask

  task automatic test_stop_reset();
    do_reset();
    tx_ready = 0;
    bus(32'h00100, 8'hC3, 1'b1);
    bus(32'h30000, 8'h77, 1'b1);
    bus(32'h30004, 8'h99, 1'b1);
    n_checks++; if (program_stop !== 1'b1) begin n_fail++; $display("FAIL stop_set: got %b want 1", program_stop); end
    tx_ready = 1;
    for (int k = 0; k < 8 && m_q.size() > 0; k++) begin
      if (m_q.size() == 1) begin
        n_checks++; if (tx_data !== 8'h00 || tx_valid !== 1'b1) begin n_fail++;
          $display("FAIL stop_marker: got v=%b d=%h want 1 00", tx_valid, tx_data); end
      end
      bus(32'h30008, 8'h00, 1'b0);
    end
    tx_ready = 0;
    bus(32'h30000, 8'h42, 1'b1);
    bus(32'h00100, 8'h00, 1'b0);
    n_checks++; if (bus_rdata !== 8'hC3) begin n_fail++; $display("FAIL pre_reset_read: got %h want c3", bus_rdata); end
    bus_a = 32'h00100; bus_wr = 0;
    #2 rst_in = 1'b0;
    model_reset();
    #1;
    n_checks++; if (bus_rdata !== 8'h00 || program_stop !== 1'b0 || tx_valid !== 1'b0 || tx_overflow !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got rd=%h stop=%b v=%b ovf=%b want 00 0 0 0",
                         bus_rdata, program_stop, tx_valid, tx_overflow); end
    @(posedge clk_in);
    @(negedge clk_in); rst_in = 1'b1;
    bus(32'h00100, 8'h00, 1'b0);
    n_checks++; if (bus_rdata !== 8'hC3) begin n_fail++; $display("FAIL ram_kept: got %h want c3", bus_rdata); end
    bus(32'h00010, 8'h00, 1'b0);
    n_checks++; if (bus_rdata !== m_rdata) begin n_fail++; $display("FAIL ram_kept2: got %h want %h", bus_rdata, m_rdata); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_ram();
    test_rx();
    test_cycle_counter();
    test_fifo();
    test_stop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Target side of the CPU byte-wide memory bus, driven by mem_ctrl through mem_a/mem_dout/mem_wr/mem_din.
- Provides the byte RAM and the memory-mapped I/O at 0x30000/0x30004: UART RX/TX buffering, the cycle counter and the program-stop flag.
- Used as the CPU's memory/IO model in simulation and as the RAM+IO wrapper on board.

Parameters:
- RAM_ADDR_WIDTH, 17, log2 of RAM size in bytes; RAM index = bus_a[RAM_ADDR_WIDTH-1:0].
- TX_FIFO_LOG2, 4, log2 of TX FIFO depth (default 16 entries).
- FULL_MARGIN, 2, io_buffer_full asserts when free TX entries <= FULL_MARGIN.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- bus_a  input  32  byte address from CPU; only [17:0] decoded.
- bus_wdata  input  8  write byte from CPU.
- bus_wr  input  1  1 = write, 0 = read.
- bus_rdata  output  8  read byte to CPU, registered.
- io_buffer_full  output  1  TX FIFO near full, to CPU.
- tx_data  output  8  TX FIFO head byte to UART.
- tx_valid  output  1  TX FIFO non-empty.
- tx_ready  input  1  UART accepts head byte this cycle.
- rx_data  input  8  UART received byte.
- rx_valid  input  1  rx_data holds an unread byte.
- rx_pop  output  1  one-cycle pulse: byte consumed.
- program_stop  output  1  sticky, set by a write to 0x30004.
- tx_overflow  output  1  sticky, a TX push was dropped.

Behaviour:
- Reset (rst_in=0, async): bus_rdata=0, FIFO empty (tx_valid=0), io_buffer_full=0, rx_pop=0, program_stop=0, tx_overflow=0, cycle_cnt=0, snapshot=0. RAM contents are not reset.
- Decode: io = (bus_a[17:16]==2'b11). Every other address is RAM.
- Every cycle is a transaction; the bus has no idle encoding. A read of RAM has no side effects.
- RAM read: bus_rdata <= ram[idx] at posedge, so data is valid the cycle after the address (1-cycle latency).
- RAM write: ram[idx] <= bus_wdata at posedge; no response.
- Read 0x30000: if rx_valid, bus_rdata <= rx_data and rx_pop pulses for that same cycle; else bus_rdata <= 0x00 and no pop.
- Read 0x30004: bus_rdata <= cycle_cnt[7:0] and snapshot <= cycle_cnt[31:8]. Reads of 0x30005/6/7 return snapshot bytes [15:8]/[23:16]/[31:24], giving a coherent 32-bit value over four byte reads.
- Other io reads return 0x00.
- Write 0x30000: push bus_wdata to the TX FIFO if it is non-zero. A write of 0x00 is ignored.
- Write 0x30004: set program_stop and push 0x00 to the TX FIFO.
- Other io writes are ignored.
- cycle_cnt increments every clock from reset release and wraps 0xFFFFFFFF -> 0.
- TX FIFO: circular buffer with TX_FIFO_LOG2+1 bit pointers. tx_data = head and is valid whenever tx_valid=1. A pop occurs when tx_valid && tx_ready.
- Full with simultaneous pop and push: both happen and count is unchanged.
- Full, push, no pop: byte dropped and tx_overflow set.
- Empty with tx_ready high: no pop.
- io_buffer_full is combinational from count: (2^TX_FIFO_LOG2 - count) <= FULL_MARGIN.
- program_stop and tx_overflow clear only on reset.
- Reset mid-read: the bus_rdata of the pending read is lost (0).

Optional Feature:
- Macro: MEM_IO_BOUNDS_CHECK_EN.
- Defined: a non-io address with bus_a[17:0] >= 2^RAM_ADDR_WIDTH is a fault. Writes are suppressed, reads return 0x00, and an extra output port access_fault (1 bit, sticky, reset 0) is set.
- Undefined: the index is truncated, the address aliases into RAM, and no access_fault port exists.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 -> bus_rdata=0xA5 exactly one cycle after the read address; an earlier-cycle sample differs.
- With rx_valid=1 and rx_data=0x41, read 0x30000 -> rx_pop pulses one cycle, then bus_rdata=0x41. With rx_valid=0 -> bus_rdata=0x00 and no pop.
- Release reset, wait 300 cycles, read 0x30004..0x30007 on consecutive cycles -> assembled value equals cycle_cnt at the 0x30004 read (±0) and is stable across bytes.
- tx_ready=0: write 'a'..'p' (16 bytes) to 0x30000 -> io_buffer_full rises when count reaches 14. A 17th write sets tx_overflow. A write of 0x00 leaves count unchanged.
- FIFO full, tx_ready=1, write 0x58 in the same cycle -> count stays 16, no overflow, tx_data order preserved.
- Write 0x30004 -> program_stop=1, 0x00 appears at the FIFO tail. Assert rst_in=0 mid-sequence -> all flags and bus_rdata clear asynchronously; RAM data from before reset is still readable.
